// File: rtl/schoolbook_pkg.sv
// Shared types and helpers for the digit-serial schoolbook multiplier.
// Optional feature macro: SCHOOLBOOK_GF2_EN (carry-less mode port on the top).
package schoolbook_pkg;

    // Controller states; IDLE and DONE both accept a new start.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Multiplication mode encoding as carried through the datapath.
    localparam logic MODE_INT = 1'b0;
    localparam logic MODE_GF2 = 1'b1;

    // Number of DIGIT-wide slices needed to cover a w-bit operand.
    function automatic int ceil_div(input int n, input int d);
        return (n + d - 1) / d;
    endfunction

    // Counter width able to hold the value ndig (the counter stops there).
    function automatic int cnt_width(input int ndig);
        return (ndig < 1) ? 1 : $clog2(ndig + 1);
    endfunction

endpackage

// File: rtl/schoolbook_digit_pp.sv
// A_W x DIGIT partial product: integer product or carry-less (GF(2)[x]) product.
// Optional feature macro: SCHOOLBOOK_GF2_EN (selects whether mode_i is ever driven to GF2).
module schoolbook_digit_pp
    import schoolbook_pkg::*;
#(
    parameter int A_W   = 163,
    parameter int DIGIT = 4
) (
    input  logic [A_W-1:0]       a_i,
    input  logic [DIGIT-1:0]     d_i,
    input  logic                 mode_i,
    output logic [A_W+DIGIT-1:0] pp_o
);

    localparam int PP_W = A_W + DIGIT;

    logic [PP_W-1:0] int_pp;
    logic [PP_W-1:0] clmul_pp;

    // Ordinary integer product of the multiplicand and one digit.
    always_comb begin
        int_pp = PP_W'(a_i) * PP_W'(d_i);
    end

    // Carry-less product: XOR of shifted copies of a for every set digit bit.
    always_comb begin
        clmul_pp = '0;
        for (int j = 0; j < DIGIT; j++) begin
            if (d_i[j]) begin
                clmul_pp = clmul_pp ^ (PP_W'(a_i) << j);
            end
        end
    end

    assign pp_o = (mode_i == MODE_GF2) ? clmul_pp : int_pp;

endmodule

// File: rtl/schoolbook_serial.sv
// Digit-serial schoolbook multiplier: c = a * b, DIGIT bits of b per cycle.
// Optional feature macro: SCHOOLBOOK_GF2_EN adds input 'mode' (0 = integer,
// 1 = carry-less GF(2)[x] product); without it only integer products exist.
//
// Handshake: a request is accepted on a rising edge where start=1 and ready=1.
// ready is high in IDLE and DONE, low while RUN scans digits. done is a
// one-cycle pulse (the DONE state) meaning c holds a new product; c is only
// rewritten at completion edges. start while ready=0 is ignored.
module schoolbook_serial
    import schoolbook_pkg::*;
#(
    parameter int A_W   = 163,
    parameter int B_W   = 163,
    parameter int DIGIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
`ifdef SCHOOLBOOK_GF2_EN
    input  logic               mode,
`endif
    output logic               ready,
    output logic               done,
    output logic [A_W+B_W-1:0] c,
    output logic [1:0]         dbg_state_o
);

    localparam int NDIG = ceil_div(B_W, DIGIT);
    localparam int BX_W = NDIG * DIGIT;
    localparam int CW   = cnt_width(NDIG);
    localparam int P_W  = A_W + B_W;
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    state_e             state_q, state_d;
    logic [A_W-1:0]     a_q, a_d;
    logic [BX_W-1:0]    b_q, b_d;
    logic               mode_q, mode_d;
    logic [P_W-1:0]     acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [P_W-1:0]     c_q, c_d;

    logic               mode_in;
    logic [A_W+DIGIT-1:0] pp;
    logic [P_W-1:0]     pp_sh;
    logic [P_W-1:0]     acc_sum;
    logic [31:0]        shamt;

`ifdef SCHOOLBOOK_GF2_EN
    assign mode_in = mode;
`else
    assign mode_in = MODE_INT;
`endif

    // b_q is shifted down each RUN cycle, so the current digit is always its low slice.
    schoolbook_digit_pp #(
        .A_W   (A_W),
        .DIGIT (DIGIT)
    ) u_pp (
        .a_i    (a_q),
        .d_i    (b_q[DIGIT-1:0]),
        .mode_i (mode_q),
        .pp_o   (pp)
    );

    assign shamt = 32'(cnt_q) * 32'(DIGIT);

    // Align the partial product to its digit position and fold it into the accumulator.
    always_comb begin
        pp_sh   = P_W'(pp) << shamt;
        acc_sum = (mode_q == MODE_GF2) ? (acc_q ^ pp_sh) : (acc_q + pp_sh);
    end

    // Next-state logic for the controller, counter and datapath registers.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        mode_d  = mode_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        c_d     = c_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = RUN;
                    a_d     = a;
                    b_d     = BX_W'(b);
                    mode_d  = mode_in;
                    acc_d   = '0;
                    cnt_d   = '0;
                end else if (state_q == DONE) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                acc_d = acc_sum;
                b_d   = b_q >> DIGIT;
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST) begin
                    state_d = DONE;
                    c_d     = acc_sum;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any running operation.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            mode_q  <= MODE_INT;
            acc_q   <= '0;
            cnt_q   <= '0;
            c_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            mode_q  <= mode_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            c_q     <= c_d;
        end
    end

    assign ready       = (state_q != RUN);
    assign done        = (state_q == DONE);
    assign c           = c_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_schoolbook_serial.sv
// Self-checking bench for schoolbook_serial: driver tasks push expected
// products into a queue; a negedge monitor pops and compares on every done.
module tb_schoolbook_serial;
  import schoolbook_pkg::*;

  localparam int A_W   = 163;
  localparam int B_W   = 163;
  localparam int DIGIT = 4;
  localparam int NDIG  = (B_W + DIGIT - 1) / DIGIT;
  localparam int P_W   = A_W + B_W;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic           start = 1'b0;
  logic [A_W-1:0] a = '0;
  logic [B_W-1:0] b = '0;
`ifdef SCHOOLBOOK_GF2_EN
  logic           mode = 1'b0;
`endif
  logic           ready;
  logic           done;
  logic [P_W-1:0] c;
  logic [1:0]     dbg_state;

  schoolbook_serial #(.A_W(A_W), .B_W(B_W), .DIGIT(DIGIT)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .a           (a),
    .b           (b),
`ifdef SCHOOLBOOK_GF2_EN
    .mode        (mode),
`endif
    .ready       (ready),
    .done        (done),
    .c           (c),
    .dbg_state_o (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  logic [P_W-1:0] exp_q[$];
  int             acc_cyc_q[$];
  int             n_checks = 0;
  int             n_pass = 0;

  task automatic check_val(input string name, input logic [P_W-1:0] act, input logic [P_W-1:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h required %h", name, act, exp);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d required %0d", name, act, exp);
  endtask

  // Reference: plain integer product, or carry-less product bit by bit over b.
  function automatic logic [P_W-1:0] ref_mul(input logic [A_W-1:0] x, input logic [B_W-1:0] y, input logic gf2);
    logic [P_W-1:0] r;
    r = '0;
    if (!gf2) r = P_W'(x) * P_W'(y);
    else begin
      for (int i = 0; i < B_W; i++)
        if (y[i]) r = r ^ (P_W'(x) << i);
    end
    return r;
  endfunction

  function automatic logic [A_W-1:0] rnd_a();
    logic [A_W+31:0] r;
    r = '0;
    for (int i = 0; i < (A_W + 31) / 32; i++) r = {r[A_W-1:0], 32'($urandom())};
    return r[A_W-1:0];
  endfunction

  function automatic logic [B_W-1:0] rnd_b();
    logic [B_W+31:0] r;
    r = '0;
    for (int i = 0; i < (B_W + 31) / 32; i++) r = {r[B_W-1:0], 32'($urandom())};
    return r[B_W-1:0];
  endfunction

  // Monitor: every done pops one expected product and its accept cycle.
  logic [P_W-1:0] mon_exp;
  int             mon_t;
  always @(negedge clk) begin
    if (rst && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        $display("FAIL unexpected_done: got done=1 required no pending result");
      end else begin
        mon_exp = exp_q.pop_front();
        mon_t   = acc_cyc_q.pop_front();
        check_val("product", c, mon_exp);
        check_int("latency", cyc - mon_t, NDIG);
      end
    end
  end

  // ---------------- driver tasks (entered and left just after a negedge) ----------------
  task automatic wait_ready();
    int k = 0;
    while (!ready && k < 2 * NDIG + 20) begin
      @(negedge clk);
      k++;
    end
    if (!ready) check_int("ready_timeout", 0, 1);
  endtask

  task automatic drive_ops(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input logic mv);
    a = av;
    b = bv;
`ifdef SCHOOLBOOK_GF2_EN
    mode = mv;
`endif
  endtask

  task automatic issue(input logic [A_W-1:0] av, input logic [B_W-1:0] bv, input logic mv);
    wait_ready();
    start = 1'b1;
    drive_ops(av, bv, mv);
    @(posedge clk);
    #1;
    exp_q.push_back(ref_mul(av, bv, mv));
    acc_cyc_q.push_back(cyc);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(output int dcyc);
    int k = 0;
    dcyc = -1;
    while (k < NDIG + 10) begin
      if (done) begin
        dcyc = cyc;
        break;
      end
      @(negedge clk);
      k++;
    end
    if (dcyc < 0) check_int("done_timeout", 0, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int             d1, d2, bad, k;
    logic [A_W-1:0] ones_a, top_a;
    logic [B_W-1:0] ones_b, top_b;

    ones_a = '1;
    ones_b = '1;
    top_a  = '0;
    top_a  = A_W'(1) << (A_W - 1);
    top_b  = '0;
    top_b  = B_W'(1) << (B_W - 1);

    // reset values
    repeat (3) @(negedge clk);
    check_val("reset_c", c, '0);
    check_int("reset_done", int'(done), 0);
    check_int("reset_ready", int'(ready), 1);
    check_int("reset_state", int'(dbg_state), int'(IDLE));
    rst = 1'b1;
    @(negedge clk);

    // 3 * 5 with ready held low for the whole run
    issue(A_W'(3), B_W'(5), 1'b0);
    bad = 0;
    for (int i = 0; i < NDIG; i++) begin
      if (ready !== 1'b0 || done !== 1'b0) bad++;
      @(negedge clk);
    end
    check_int("ready_low_in_run", bad, 0);
    wait_done(d1);
    check_val("c_3x5", c, P_W'(15));

    // all-ones operands, then zero multiplicand
    issue(ones_a, ones_b, 1'b0);
    wait_done(d1);
    issue('0, ones_b, 1'b0);
    wait_done(d1);
    check_val("c_zero", c, '0);

    // start held during RUN with changing operands, then back-to-back accept in DONE
    wait_ready();
    start = 1'b1;
    drive_ops(A_W'(11), B_W'(13), 1'b0);
    @(posedge clk);
    #1;
    exp_q.push_back(ref_mul(A_W'(11), B_W'(13), 1'b0));
    acc_cyc_q.push_back(cyc);
    @(negedge clk);
    k = 0;
    while (!done && k < NDIG + 10) begin
      drive_ops(rnd_a(), rnd_b(), 1'b0);
      @(negedge clk);
      k++;
    end
    if (done) begin
      d1 = cyc;
      drive_ops(A_W'(1000), B_W'(999), 1'b0);
      @(posedge clk);
      #1;
      exp_q.push_back(ref_mul(A_W'(1000), B_W'(999), 1'b0));
      acc_cyc_q.push_back(cyc);
      @(negedge clk);
      start = 1'b0;
      wait_done(d2);
      check_int("b2b_gap", d2 - d1, NDIG + 1);
    end else begin
      start = 1'b0;
      check_int("held_start_done_timeout", 0, 1);
    end

    // reset in the middle of a run
    issue(rnd_a(), rnd_b(), 1'b0);
    repeat (19) @(negedge clk);
    rst = 1'b0;
    #1;
    check_val("abort_c", c, '0);
    check_int("abort_done", int'(done), 0);
    check_int("abort_ready", int'(ready), 1);
    exp_q.delete();
    acc_cyc_q.delete();
    @(negedge clk);
    rst = 1'b1;
    bad = 0;
    for (int i = 0; i < NDIG + 5; i++) begin
      if (done) bad++;
      @(negedge clk);
    end
    check_int("no_done_after_abort", bad, 0);
    issue(A_W'(7), B_W'(9), 1'b0);
    wait_done(d1);
    check_val("c_7x9", c, P_W'(63));

`ifdef SCHOOLBOOK_GF2_EN
    // carry-less mode
    issue(A_W'(3), B_W'(3), 1'b1);
    wait_done(d1);
    check_val("gf2_3x3", c, P_W'(5));
    issue(top_a, top_b, 1'b1);
    wait_done(d1);
    check_val("gf2_top", c, P_W'(1) << (A_W + B_W - 2));
    issue(A_W'(3), B_W'(3), 1'b0);
    wait_done(d1);
    check_val("int_3x3", c, P_W'(9));
`else
    issue(top_a, top_b, 1'b0);
    wait_done(d1);
`endif

    // random operands, some back-to-back and some with idle gaps
    for (int n = 0; n < 12; n++) begin
      logic [A_W-1:0] ra;
      logic [B_W-1:0] rb;
      logic           rm;
      ra = rnd_a();
      rb = rnd_b();
      if ($urandom_range(0, 3) == 0) ra = ra & A_W'($urandom());
      if ($urandom_range(0, 3) == 0) rb = rb >> $urandom_range(0, B_W - 1);
`ifdef SCHOOLBOOK_GF2_EN
      rm = 1'($urandom_range(0, 1));
`else
      rm = 1'b0;
`endif
      issue(ra, rb, rm);
      wait_done(d1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (3) @(negedge clk);
    check_int("queue_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
